counter_bank_with_strobe: RTL and testbench

- Parametrised bank of CHANNELS independent tick counters; each channel emits a one-cycle strobe every Nth enabled tick.
- Adds three capabilities: a per-channel periodic or one-shot mode, a glitch-free period update through a shadow register, and a done/arm handshake for one-shot channels.
- Used as the shared timebase and prescaler block for peripherals such as UART baud ticks, PWM frame ticks and watchdog timeouts.

---
 rtl/counter_bank_pkg.sv | 16 +
 rtl/counter_bank_channel.sv | 74 +++++++
 rtl/counter_bank_with_strobe.sv | 56 +++++
 tb/tb_counter_bank_with_strobe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_bank_pkg.sv
// Shared definitions for the counter bank: mode encoding, counter
// restart value and the period_in slice helper.
package counter_bank_pkg;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

    localparam int CNT_RESET = 1;

    function automatic int period_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/counter_bank_channel.sv
// One prescaler channel: tick counter, shadowed period, one-shot done
// latch and a registered terminal-count strobe.
module counter_bank_channel
    import counter_bank_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_src,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    input  logic             period_wr,
    input  logic             arm,
    output logic             strobe,
    output logic             done
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(CNT_RESET);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] active_period;
    logic [WIDTH-1:0] shadow_period;
    logic             pending;
    logic             tick;
    logic             term;
    logic             load_now;

    assign tick = tick_src && !done && (active_period != '0);
    assign term = tick && (cnt == active_period);

    // Safe to switch period immediately when no count is in flight
    assign load_now = (active_period == '0) || done
                    || ((cnt == CNT_ONE) && !tick) || term;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= CNT_ONE;
            active_period <= '0;
            shadow_period <= '0;
            pending       <= 1'b0;
            strobe        <= 1'b0;
            done          <= 1'b0;
        end else begin
            strobe <= term;

            if (arm || term) begin
                cnt <= CNT_ONE;
            end else if (tick) begin
                cnt <= cnt + WIDTH'(1);
            end

            if (arm) begin
                done <= 1'b0;
            end else if (term && (mode == MODE_ONESHOT)) begin
                done <= 1'b1;
            end

            if (period_wr) begin
                shadow_period <= period;
                if (load_now) begin
                    active_period <= period;
                    pending       <= 1'b0;
                end else begin
                    pending <= 1'b1;
                end
            end else if (term && pending) begin
                active_period <= shadow_period;
                pending       <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/counter_bank_with_strobe.sv
// Bank of CHANNELS prescaler channels. Optional COUNTER_BANK_CASCADE_EN
// lets channel i count strobes of channel i-1 instead of enable[i].
module counter_bank_with_strobe
    import counter_bank_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS*WIDTH-1:0] period_in,
    input  logic [CHANNELS-1:0]       period_wr,
    input  logic [CHANNELS-1:0]       arm,
`ifdef COUNTER_BANK_CASCADE_EN
    input  logic [CHANNELS-1:0]       cascade,
`endif
    output logic [CHANNELS-1:0]       strobe,
    output logic [CHANNELS-1:0]       done
);

    logic [CHANNELS-1:0] tick_src;

`ifdef COUNTER_BANK_CASCADE_EN
    logic unused_cascade0;
    assign unused_cascade0 = cascade[0];
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
`ifdef COUNTER_BANK_CASCADE_EN
        if (i == 0) begin : g_src
            assign tick_src[i] = enable[i];
        end else begin : g_src
            assign tick_src[i] = cascade[i] ? strobe[i-1] : enable[i];
        end
`else
        assign tick_src[i] = enable[i];
`endif

        counter_bank_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick_src  (tick_src[i]),
            .mode      (mode[i]),
            .period    (period_in[period_lsb(i, WIDTH) +: WIDTH]),
            .period_wr (period_wr[i]),
            .arm       (arm[i]),
            .strobe    (strobe[i]),
            .done      (done[i])
        );
    end

endmodule

// File: tb/tb_counter_bank_with_strobe.sv
// Scoreboard bench for counter_bank_with_strobe: directed scenarios
// followed by random traffic against a tick-counting reference model.
module tb_counter_bank_with_strobe;

    localparam int W = 8;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [C-1:0]   enable = '0;
    logic [C-1:0]   mode = '0;
    logic [C*W-1:0] period_in = '0;
    logic [C-1:0]   period_wr = '0;
    logic [C-1:0]   arm = '0;
    logic [C-1:0]   strobe;
    logic [C-1:0]   done;
`ifdef COUNTER_BANK_CASCADE_EN
    logic [C-1:0]   cascade = '0;
`endif

    counter_bank_with_strobe #(
        .WIDTH(W),
        .CHANNELS(C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .mode      (mode),
        .period_in (period_in),
        .period_wr (period_wr),
        .arm       (arm),
`ifdef COUNTER_BANK_CASCADE_EN
        .cascade   (cascade),
`endif
        .strobe    (strobe),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference model: ticks counted so far in the current period
    int           per  [C];
    int           shd  [C];
    int           seen [C];
    bit           pend [C];
    bit           dn   [C];
    logic [C-1:0] mstb = '0;

    logic [2*C-1:0] exp_q[$];
    int passed = 0;
    int total  = 0;
    int s0     = 0;

    task automatic model_step();
        logic [C-1:0] nstb;
        logic [C-1:0] ndn;
        nstb = '0;
        ndn  = '0;
        for (int i = 0; i < C; i++) begin
            bit src, tk, fire, quiet;
            int val;
            if (rst) begin
                per[i] = 0; shd[i] = 0; seen[i] = 0;
                pend[i] = 0; dn[i] = 0;
            end else begin
                src = enable[i];
`ifdef COUNTER_BANK_CASCADE_EN
                if (i > 0 && cascade[i]) src = mstb[i-1];
`endif
                tk    = src && !dn[i] && per[i] != 0;
                fire  = tk && (seen[i] + 1 == per[i]);
                quiet = per[i] == 0 || dn[i] || (seen[i] == 0 && !tk);
                val   = int'(period_in[i*W +: W]);
                nstb[i] = fire;
                if (period_wr[i]) begin
                    shd[i] = val;
                    if (quiet || fire) begin
                        per[i] = val; pend[i] = 0;
                    end else begin
                        pend[i] = 1;
                    end
                end else if (fire && pend[i]) begin
                    per[i] = shd[i]; pend[i] = 0;
                end
                if (arm[i] || fire) seen[i] = 0;
                else if (tk) seen[i] = seen[i] + 1;
                if (arm[i]) dn[i] = 0;
                else if (fire && mode[i]) dn[i] = 1;
            end
            ndn[i] = dn[i];
        end
        mstb = nstb;
        exp_q.push_back({nstb, ndn});
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        if (strobe[0]) s0++;
        @(negedge clk);
        period_wr = '0;
        arm       = '0;
    endtask

    task automatic cycles(input int n);
        repeat (n) cyc();
    endtask

    task automatic set_p(input int ch, input int val);
        period_in[ch*W +: W] = W'(val);
        period_wr[ch] = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = '0;
        mode = '0;
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s got=%0d want=%0d", name, got, want);
    endtask

    // Monitor: compare every registered output cycle against the queue
    initial begin
        logic [2*C-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if ({strobe, done} === e) begin
                    passed++;
                end else begin
                    $display("FAIL cycle t=%0t strobe=%b done=%b want strobe=%b done=%b",
                             $time, strobe, done, e[2*C-1:C], e[C-1:0]);
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        do_reset();
        cycles(3);

        // P=5 continuous: ten strobes in fifty ticks
        set_p(0, 5);
        cyc();
        s0 = 0;
        enable[0] = 1'b1;
        cycles(50);
        enable[0] = 1'b0;
        cyc();
        check_int("p5_strobe_count", s0, 10);

        // P=3 with gaps in enable
        set_p(1, 3);
        cyc();
        for (int r = 0; r < 2; r++) begin
            logic [7:0] pat;
            pat = 8'b1100_1101;
            for (int b = 0; b < 8; b++) begin
                enable[1] = pat[b];
                cyc();
            end
        end
        enable[1] = 1'b0;

        // Shadow update mid-count, then writes landing on terminal ticks
        set_p(2, 4);
        cyc();
        enable[2] = 1'b1;
        cyc();
        set_p(2, 2);
        cycles(10);
        for (int r = 0; r < 6; r++) begin
            set_p(2, 2 + (r % 2));
            cycles(2);
        end
        enable[2] = 1'b0;

        // One-shot, arm, and arm on the terminal cycle
        mode[3] = 1'b1;
        set_p(3, 3);
        cyc();
        enable[3] = 1'b1;
        cycles(8);
        arm[3] = 1'b1;
        cyc();
        cycles(6);
        arm[3] = 1'b1;
        cyc();
        cycles(2);
        arm[3] = 1'b1;
        cycles(6);
        enable[3] = 1'b0;
        mode[3] = 1'b0;

        // P=1, then the widest period, then reset mid-count
        do_reset();
        cycles(5);
        enable = '1;
        cycles(3);
        set_p(0, 1);
        set_p(1, (1 << W) - 1);
        cycles((1 << W) + 4);
        set_p(2, 7);
        cycles(4);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cycles(10);
        enable = '0;

`ifdef COUNTER_BANK_CASCADE_EN
        do_reset();
        set_p(0, 3);
        set_p(1, 4);
        cascade[1] = 1'b1;
        cyc();
        enable[0] = 1'b1;
        cycles(40);
        enable = '0;
        cascade = '0;
`endif

        // Random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < C; i++) begin
                enable[i] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 19) == 0) mode[i] = ~mode[i];
                if ($urandom_range(0, 7) == 0) set_p(i, $urandom_range(0, 6));
                arm[i] = ($urandom_range(0, 15) == 0);
`ifdef COUNTER_BANK_CASCADE_EN
                if ($urandom_range(0, 49) == 0) cascade[i] = ~cascade[i];
`endif
            end
            cyc();
        end
        rst = 1'b0;
        enable = '0;
        cycles(2);

        repeat (4) begin
            if (exp_q.size() != 0) @(negedge clk);
        end
        check_int("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
